// File: rtl/acl_int_service_ctrl.sv
// Accelerometer interrupt service controller: turns a level interrupt into one
// status-register read over the SPI command driver, with a watchdog and a re-arm holdoff.
//
//   state      | meaning
//   ST_IDLE    | armed, waiting for enable and interrupt level
//   ST_REQ     | o_cmd_req high, waiting for driver ack
//   ST_WAIT    | read accepted, waiting for driver done
//   ST_HOLDOFF | re-arm delay after a service or a timeout
module acl_int_service_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned HOLDOFF_CYCLES = 20
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rstn_20mhz,
  input  logic        i_int_deb,
  input  logic        i_enable,
  output logic        o_cmd_req,
  input  logic        i_cmd_ack,
  input  logic        i_cmd_done,
  output logic        o_evt_valid,
  output logic        o_timeout,
  output logic        o_busy,
  output logic [15:0] o_evt_count,
  output logic [7:0]  o_miss_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLDOFF} state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] HO_LAST = 16'(HOLDOFF_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        int_prev;
  logic        evt_nxt, to_nxt;
  logic        wd_exp, ho_done, int_rise, cnt_clear;

  assign wd_exp   = (cnt == WD_LAST);
  assign ho_done  = (cnt == HO_LAST);
  assign int_rise = i_int_deb & ~int_prev;

  // One counter serves as watchdog (REQ+WAIT, not cleared on REQ->WAIT) and holdoff timer.
  assign cnt_clear = (state_nxt != state) &&
                     ((state_nxt == ST_REQ) || (state_nxt == ST_HOLDOFF));

  always_comb begin
    state_nxt = state;
    evt_nxt   = 1'b0;
    to_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_enable && i_int_deb) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (i_cmd_ack) begin
          state_nxt = ST_WAIT;
        end else if (wd_exp) begin
          state_nxt = ST_HOLDOFF;
          to_nxt    = 1'b1;
        end else if (!i_enable) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (i_cmd_done) begin
          state_nxt = ST_HOLDOFF;
          evt_nxt   = 1'b1;
        end else if (wd_exp) begin
          state_nxt = ST_HOLDOFF;
          to_nxt    = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (ho_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      state        <= ST_IDLE;
      cnt          <= 16'd0;
      int_prev     <= 1'b0;
      o_evt_valid  <= 1'b0;
      o_timeout    <= 1'b0;
      o_evt_count  <= 16'd0;
      o_miss_count <= 8'd0;
    end else begin
      state       <= state_nxt;
      int_prev    <= i_int_deb;
      o_evt_valid <= evt_nxt;
      o_timeout   <= to_nxt;
      if (cnt_clear) begin
        cnt <= 16'd0;
      end else if (state != ST_IDLE) begin
        cnt <= cnt + 16'd1;
      end
      if (evt_nxt && (o_evt_count != 16'hFFFF)) begin
        o_evt_count <= o_evt_count + 16'd1;
      end
      if (int_rise && (state != ST_IDLE) && (o_miss_count != 8'hFF)) begin
        o_miss_count <= o_miss_count + 8'd1;
      end
    end
  end

  assign o_cmd_req = (state == ST_REQ);
  assign o_busy    = (state != ST_IDLE);

endmodule
